gnr_attractor_ctrl: RTL and testbench

GNR_ATTRACTOR_CTRL -- requirements
Module: gnr_attractor_ctrl

---
 rtl/gnr_pkg.sv | 24 ++
 rtl/gnr_step_ctr.sv | 52 +++++
 rtl/gnr_attractor_ctrl.sv | 130 +++++++++++++
 tb/tb_gnr_attractor_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gnr_pkg.sv
// Shared types and default sizing for the GNR attractor sweep controller.
package gnr_pkg;

  localparam int GNR_N_NODES   = 8;
  localparam int GNR_STEP_W    = 12;
  localparam int GNR_MAX_STEPS = 2048;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_REPORT = 3'd4,
    ST_FINISH = 3'd5
  } gnr_state_e;

  typedef struct packed {
    logic [GNR_N_NODES-1:0] init;
    logic [GNR_N_NODES-1:0] state;
    logic [GNR_STEP_W-1:0]  steps;
    logic                   timeout;
  } gnr_result_t;

endpackage

// File: rtl/gnr_step_ctr.sv
// Advance-pulse counter with the even/nonzero match qualifier and, when
// GNR_CTRL_TIMEOUT_EN is defined, the step-limit compare.
module gnr_step_ctr #(
  parameter int STEP_W    = 12,
  parameter int MAX_STEPS = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [STEP_W-1:0] steps_o,
  output logic              qual_o,
  output logic              limit_o
);

  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  if (MAX_STEPS < 1 || MAX_STEPS >= (1 << STEP_W)) begin : g_limit_range
    $error("MAX_STEPS must be nonzero and representable in STEP_W bits");
  end

  logic [STEP_W-1:0] steps_q, steps_d;

  always_comb begin
    steps_d = steps_q;
    if (clr_i) begin
      steps_d = '0;
    end else if (inc_i) begin
      steps_d = steps_q + STEP_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      steps_q <= '0;
    end else begin
      steps_q <= steps_d;
    end
  end

  assign steps_o = steps_q;
  // Slow and fast copies are only comparable after an even number of pulses.
  assign qual_o  = (steps_q != '0) && !steps_q[0];

`ifdef GNR_CTRL_TIMEOUT_EN
  localparam logic [STEP_W-1:0] LIMIT = STEP_W'(MAX_STEPS);
  assign limit_o = (steps_q == LIMIT);
`else
  assign limit_o = 1'b0;
`endif

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Sweeps a range of initial network states, running tortoise/hare advance
// pulses until the copies meet. Optional step limit: GNR_CTRL_TIMEOUT_EN.
module gnr_attractor_ctrl
  import gnr_pkg::*;
#(
  parameter int N_NODES   = GNR_N_NODES,
  parameter int STEP_W    = GNR_STEP_W,
  parameter int MAX_STEPS = GNR_MAX_STEPS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] init_base,
  input  logic [N_NODES:0]   init_count,
  output logic               reset_nos,
  output logic               start_s0,
  output logic               start_s1,
  output logic [N_NODES-1:0] init_state,
  input  logic [N_NODES-1:0] net_s0,
  input  logic [N_NODES-1:0] net_s1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_NODES-1:0] out_init,
  output logic [N_NODES-1:0] out_state,
  output logic [STEP_W-1:0]  out_steps,
  output logic               out_timeout,
  output logic               busy,
  output logic               done
);

  localparam logic [N_NODES-1:0] NODE_ONE = N_NODES'(1);
  localparam logic [N_NODES:0]   REM_ONE  = (N_NODES + 1)'(1);

  gnr_state_e         state_q;
  logic [N_NODES-1:0] cur_init_q;
  logic [N_NODES:0]   remaining_q;
  logic [N_NODES-1:0] res_init_q;
  logic [N_NODES-1:0] res_state_q;
  logic [STEP_W-1:0]  res_steps_q;
`ifdef GNR_CTRL_TIMEOUT_EN
  logic               res_tmo_q;
`endif

  logic [STEP_W-1:0]  steps;
  logic               qual;
  logic               limit;
  logic               match;
  logic               advance;

  gnr_step_ctr #(
    .STEP_W    (STEP_W),
    .MAX_STEPS (MAX_STEPS)
  ) u_step_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (state_q == ST_LOAD),
    .inc_i   (advance),
    .steps_o (steps),
    .qual_o  (qual),
    .limit_o (limit)
  );

  // The check looks at the copies before this cycle's pulse; a hit or the
  // limit suppresses the pulse so the reported state is the compared one.
  assign match   = qual && (net_s0 == net_s1);
  assign advance = (state_q == ST_RUN) && !match && !limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_init_q  <= '0;
      remaining_q <= '0;
      res_init_q  <= '0;
      res_state_q <= '0;
      res_steps_q <= '0;
`ifdef GNR_CTRL_TIMEOUT_EN
      res_tmo_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cur_init_q  <= init_base;
            remaining_q <= init_count;
            state_q     <= (init_count == '0) ? ST_FINISH : ST_LOAD;
          end
        end
        ST_LOAD:   state_q <= ST_SETTLE;
        ST_SETTLE: state_q <= ST_RUN;
        ST_RUN: begin
          if (match || limit) begin
            res_init_q  <= cur_init_q;
            res_state_q <= net_s1;
            res_steps_q <= steps;
`ifdef GNR_CTRL_TIMEOUT_EN
            res_tmo_q   <= !match;
`endif
            state_q     <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (out_ready) begin
            cur_init_q  <= cur_init_q + NODE_ONE;
            remaining_q <= remaining_q - REM_ONE;
            state_q     <= (remaining_q != REM_ONE) ? ST_LOAD : ST_FINISH;
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign reset_nos  = (state_q == ST_LOAD);
  assign init_state = reset_nos ? cur_init_q : '0;
  assign start_s0   = advance;
  assign start_s1   = advance;
  assign out_valid  = (state_q == ST_REPORT);
  assign out_init   = res_init_q;
  assign out_state  = res_state_q;
  assign out_steps  = res_steps_q;
`ifdef GNR_CTRL_TIMEOUT_EN
  assign out_timeout = res_tmo_q;
`else
  assign out_timeout = 1'b0;
`endif
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_FINISH);

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl: node network plant plus an iterate-and-compare
// reference model of the sweep results.
module tb_gnr_attractor_ctrl;
  import gnr_pkg::*;

  localparam int N     = GNR_N_NODES;
  localparam int SW    = GNR_STEP_W;
  localparam int MAXS  = 300;
  localparam int BOUND = 5000;
`ifdef GNR_CTRL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  init_base = '0;
  logic [N:0]    init_count = '0;
  logic          out_ready = 1'b0;
  logic          reset_nos, start_s0, start_s1, out_valid, out_timeout, busy, done;
  logic [N-1:0]  init_state, out_init, out_state;
  logic [SW-1:0] out_steps;
  logic [N-1:0]  s0 = '0, s1 = '0;
  logic          tog = 1'b0;

  int n_tests = 0, n_fail = 0;
  int mode = 0;
  logic [N-1:0] ftab [256];

  gnr_result_t got [$];
  int rn_cnt, done_cnt, unstable, strobe_rep, init_bad, conflict, acc_cyc, done_cyc;
  bit sweep_to, done_long;

  gnr_attractor_ctrl #(.N_NODES(N), .STEP_W(SW), .MAX_STEPS(MAXS)) dut (
    .clk(clk), .rst(rst), .start(start), .init_base(init_base), .init_count(init_count),
    .reset_nos(reset_nos), .start_s0(start_s0), .start_s1(start_s1), .init_state(init_state),
    .net_s0(s0), .net_s1(s1), .out_valid(out_valid), .out_ready(out_ready),
    .out_init(out_init), .out_state(out_state), .out_steps(out_steps),
    .out_timeout(out_timeout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] fnet(input logic [N-1:0] x);
    case (mode)
      0:       return x;
      1:       return x + 8'd1;
      default: return ftab[x];
    endcase
  endfunction

  // Node plant: fast copy steps every pulse, slow copy every second pulse.
  always @(posedge clk) begin
    if (reset_nos) begin
      s0 <= init_state; s1 <= init_state; tog <= 1'b0;
    end else if (start_s1) begin
      s1 <= fnet(s1);
      if (start_s0 && tog) s0 <= fnet(s0);
      tog <= ~tog;
    end
  end

  // Reference: after k pulses the hare sits at f^k(x), the tortoise at f^(k/2)(x).
  function automatic gnr_result_t model(input logic [N-1:0] x);
    gnr_result_t r;
    logic [N-1:0] a, b;
    int k;
    a = x; b = x; k = 0;
    r.init = x; r.timeout = 1'b0;
    while (k < 8192) begin
      if (k != 0 && (k % 2) == 0 && a == b) break;
      if (TMO_EN && k == MAXS) begin r.timeout = 1'b1; break; end
      b = fnet(b);
      if ((k % 2) == 1) a = fnet(a);
      k++;
    end
    r.state = b;
    r.steps = SW'(k);
    return r;
  endfunction

  task automatic run_sweep(input logic [N-1:0] base, input logic [N:0] cnt,
                           input int stall, input bit jitter);
    gnr_result_t snap, cur;
    bit have_snap;
    int wait_n;
    got.delete();
    rn_cnt = 0; done_cnt = 0; unstable = 0; strobe_rep = 0; init_bad = 0;
    acc_cyc = -1; done_cyc = -1; sweep_to = 1'b1; done_long = 1'b0;
    have_snap = 1'b0; wait_n = 0; snap = '0;
    @(negedge clk);
    init_base = base; init_count = cnt; start = 1'b1;
    for (int cyc = 1; cyc <= BOUND; cyc++) begin
      @(negedge clk);
      if (reset_nos && (start_s0 || start_s1)) conflict++;
      if (start_s0 !== start_s1) conflict++;
      if (reset_nos) begin
        rn_cnt++;
        if (init_state !== base + N'(got.size())) init_bad++;
      end
      if (out_valid) begin
        cur = '{init: out_init, state: out_state, steps: out_steps, timeout: out_timeout};
        if (!have_snap) begin snap = cur; have_snap = 1'b1; wait_n = 0; end
        else if (cur !== snap) unstable++;
        if (start_s0 || start_s1) strobe_rep++;
        out_ready = (wait_n >= stall);
        wait_n++;
        if (out_ready) begin got.push_back(cur); have_snap = 1'b0; acc_cyc = cyc; end
      end else begin
        out_ready = 1'($urandom % 2);
      end
      if (done) begin
        done_cnt++; done_cyc = cyc; start = 1'b0; sweep_to = 1'b0;
        break;
      end
      start = jitter ? 1'($urandom % 2) : 1'b0;
    end
    @(negedge clk);
    if (done) done_long = 1'b1;
  endtask

  task automatic test_reset();
    start = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({reset_nos, start_s0, start_s1, init_state, out_valid, out_init, out_state,
         out_steps, out_timeout, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b rn=%b valid=%b steps=%0d, all required 0",
               busy, done, reset_nos, out_valid, out_steps);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_identity();
    gnr_result_t exp;
    mode = 0;
    run_sweep(8'h5A, 9'd1, 0, 1'b0);
    exp = '{init: 8'h5A, state: 8'h5A, steps: 12'd2, timeout: 1'b0};
    n_tests++;
    if (got.size() != 1 || got[0] !== exp) begin
      n_fail++;
      $display("FAIL identity_result: n=%0d got=%h required %h", got.size(),
               (got.size() > 0) ? got[0] : '0, exp);
    end
    n_tests++;
    if (done_cyc != acc_cyc + 1 || done_long || sweep_to) begin
      n_fail++;
      $display("FAIL identity_done: done_cyc=%0d accept_cyc=%0d long=%b to=%b required done at accept+1",
               done_cyc, acc_cyc, done_long, sweep_to);
    end
    n_tests++;
    if (rn_cnt != 1 || init_bad != 0) begin
      n_fail++; $display("FAIL identity_load: reset_nos cycles=%0d bad=%0d required 1/0", rn_cnt, init_bad);
    end
  endtask

  task automatic test_increment();
    gnr_result_t exp;
    mode = 1;
    run_sweep(8'd3, 9'd1, 0, 1'b0);
    exp = TMO_EN ? '{init: 8'd3, state: 8'd47, steps: 12'd300, timeout: 1'b1}
                 : '{init: 8'd3, state: 8'd3, steps: 12'd512, timeout: 1'b0};
    n_tests++;
    if (got.size() != 1 || got[0] !== exp) begin
      n_fail++;
      $display("FAIL increment_result: n=%0d got=%h required %h", got.size(),
               (got.size() > 0) ? got[0] : '0, exp);
    end
  endtask

  task automatic test_empty();
    run_sweep(8'h11, 9'd0, 0, 1'b0);
    n_tests++;
    if (got.size() != 0 || rn_cnt != 0) begin
      n_fail++; $display("FAIL empty_activity: results=%0d loads=%0d required 0/0", got.size(), rn_cnt);
    end
    n_tests++;
    if (done_cyc != 1 || done_long) begin
      n_fail++; $display("FAIL empty_done: done_cyc=%0d long=%b required 1/0", done_cyc, done_long);
    end
  endtask

  task automatic test_stall();
    logic [N-1:0] e;
    mode = 0;
    run_sweep(8'hFF, 9'd3, 5, 1'b0);
    n_tests++;
    if (got.size() != 3) begin
      n_fail++; $display("FAIL stall_count: got %0d results required 3", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      e = 8'hFF + N'(i);
      n_tests++;
      if (got[i] !== '{init: e, state: e, steps: 12'd2, timeout: 1'b0}) begin
        n_fail++; $display("FAIL stall_result[%0d]: got %h required init=state=%h steps 2", i, got[i], e);
      end
    end
    n_tests++;
    if (unstable != 0 || strobe_rep != 0) begin
      n_fail++; $display("FAIL stall_hold: unstable=%0d strobes=%0d required 0/0", unstable, strobe_rep);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] base;
    int cnt, stall;
    gnr_result_t exp;
    for (int it = 0; it < 6; it++) begin
      mode = $urandom % 3;
      for (int j = 0; j < 256; j++) ftab[j] = N'($urandom);
      base = N'($urandom);
      cnt = $urandom_range(1, 4);
      stall = $urandom_range(0, 3);
      run_sweep(base, (N + 1)'(cnt), stall, 1'b1);
      n_tests++;
      if (got.size() != cnt || rn_cnt != cnt || sweep_to) begin
        n_fail++;
        $display("FAIL random_count[%0d]: results=%0d loads=%0d to=%b required %0d", it, got.size(), rn_cnt, sweep_to, cnt);
      end
      for (int i = 0; i < got.size(); i++) begin
        exp = model(base + N'(i));
        n_tests++;
        if (got[i] !== exp) begin
          n_fail++; $display("FAIL random_result[%0d.%0d]: got %h required %h (mode %0d)", it, i, got[i], exp, mode);
        end
      end
      n_tests++;
      if (unstable != 0 || init_bad != 0 || done_cyc != acc_cyc + 1) begin
        n_fail++;
        $display("FAIL random_protocol[%0d]: unstable=%0d init_bad=%0d done=%0d accept=%0d", it, unstable, init_bad, done_cyc, acc_cyc);
      end
    end
  endtask

  task automatic test_rst_mid();
    int seen;
    gnr_result_t exp;
    mode = 1;
    @(negedge clk);
    init_base = N'($urandom); init_count = 9'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({reset_nos, start_s0, start_s1, init_state, out_valid, out_init, out_state,
         out_steps, out_timeout, busy, done} !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs: busy=%b steps=%0d valid=%b required all 0", busy, out_steps, out_valid);
    end
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || out_valid || busy) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL rst_mid_abandon: %0d cycles of activity required 0", seen);
    end
    mode = 0;
    run_sweep(8'h80, 9'd2, 1, 1'b0);
    n_tests++;
    if (got.size() != 2 || done_cnt != 1) begin
      n_fail++; $display("FAIL rst_mid_restart_count: results=%0d dones=%0d required 2/1", got.size(), done_cnt);
    end
    for (int i = 0; i < got.size(); i++) begin
      exp = model(8'h80 + N'(i));
      n_tests++;
      if (got[i] !== exp) begin
        n_fail++; $display("FAIL rst_mid_restart[%0d]: got %h required %h", i, got[i], exp);
      end
    end
  endtask

  task automatic test_strobe_exclusion();
    n_tests++;
    if (conflict != 0) begin
      n_fail++; $display("FAIL strobe_exclusion: %0d bad strobe cycles required 0", conflict);
    end
  endtask

  initial begin
    conflict = 0;
    test_reset();
    test_identity();
    test_increment();
    test_empty();
    test_stall();
    test_random();
    test_rst_mid();
    test_strobe_exclusion();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
